mult_div_unit: RTL
==================

// Module: mult_div_unit
// PURPOSE
//  Iterative 32-bit multiply/divide unit of the MIPS datapath (MULT, MULTU, DIV, DIVU).
//  Sits in EX, directly upstream of the HI/LO register pair.
//  Takes rs/rt operands and a start pulse, computes over WIDTH+1 cycles,
//  then presents the hi/lo result with a one-cycle done strobe for the HI/LO registers to capture.
// PARAMETERS
//  WIDTH  32  operand width; hi and lo are each WIDTH bits
// PORTS
//  Clk    in   1      clock, rising-edge active
//  Reset  in   1      asynchronous, active-low reset
//  start  in   1      request; sampled only when busy=0
//  op     in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
//  a      in   WIDTH  rs operand (multiplicand / dividend); sampled with start
//  b      in   WIDTH  rt operand (multiplier / divisor); sampled with start
//  busy   out  1      high while an operation is in progress
//  done   out  1      one-cycle pulse; hi/lo valid from this cycle on
//  hi     out  WIDTH  MULT*: upper product half; DIV*: remainder
//  lo     out  WIDTH  MULT*: lower product half; DIV*: quotient
// BEHAVIOUR
//  - Reset low (async): state=IDLE; busy=0, done=0, hi=0, lo=0; internal regs cleared.
//  - FSM states:
//    - IDLE: on edge with start=1 -> RUN. Latch op; latch |a| and |b| (magnitudes for signed ops).
//      Latch the result sign: MULT a^b; DIV quotient a^b, remainder sign of a. Clear the counter.
//    - RUN: one shift-add (MUL) or restoring shift-subtract (DIV) step per edge.
//      Stays for exactly WIDTH edges; counter 0..WIDTH-1. After the WIDTH-th step -> FIX.
//    - FIX: apply two's-complement sign correction, write hi/lo, assert done. -> IDLE.
//  - Latency: start sampled at edge E0; busy=1 after E0; done=1 and busy=0 after edge E0+WIDTH+1.
//    done drops after the next edge.
//  - Back-to-back: start=1 while done=1 is accepted (busy=0); hi/lo hold until the next FIX.
//  - start while busy=1 is ignored, with no effect on the current operation or the operands.
//    Changes to a/b/op after E0 have no effect.
//  - hi/lo change only in FIX (or on reset); they hold between operations.
//  - Product: full 2*WIDTH-bit result {hi,lo}; no truncation or overflow flag.
//  - Division: quotient truncates toward zero; remainder carries the dividend's sign.
//    Invariant: a = lo*b + hi.
//  - Divide by zero (b=0, DIV or DIVU): hi=a (as supplied), lo=all ones. Latency is unchanged.
//  - DIV of most-negative by -1 (0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0.
//    No trap is raised.
//  - Most-negative operand in MULT: magnitude 0x80000000 is handled as unsigned WIDTH bits,
//    so the product is exact.
//  - Reset mid-operation: abort immediately to IDLE. Outputs are zero; no done pulse.
//  - No combinational path from inputs to outputs; every output is a register.
// TESTING
//  1. MULTU a=FFFFFFFF b=FFFFFFFF -> done after edge E0+33; hi=FFFFFFFE lo=00000001;
//     busy high for exactly 33 cycles.
//  2. MULT a=FFFFFFFD(-3) b=00000007 -> hi=FFFFFFFF lo=FFFFFFEB (-21);
//     then MULT 80000000*80000000 -> hi=40000000 lo=00000000.
//  3. DIV a=FFFFFFF9(-7) b=00000002 -> lo=FFFFFFFD (-3), hi=FFFFFFFF (-1);
//     then DIVU a=DEADBEEF b=00000010 -> lo=0DEADBEE hi=0000000F.
//  4. DIVU a=12345678 b=0 -> hi=12345678 lo=FFFFFFFF at E0+33;
//     then DIV 80000000/FFFFFFFF -> lo=80000000 hi=00000000.
//  5. Start MULTU 2*3, pulse start with a=AAAA b=5 at cycle 10 of the run -> ignored;
//     result hi=0 lo=6; exactly one done pulse.
//  6. Start DIVU, drive Reset low at cycle 15 -> busy/done/hi/lo=0 at once;
//     release and issue MULTU 67480FAC*2 -> hi=0 lo=CE901F58.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit (MULT, MULTU, DIV, DIVU) feeding the HI/LO pair.
// Operands are reduced to magnitudes, iterated for WIDTH steps, then sign-corrected.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 is_div_q, is_div_d;
    logic                 qsign_q, qsign_d;
    logic                 rsign_q, rsign_d;
    logic                 dz_q, dz_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? ('0 - x) : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] x, input logic neg);
        return neg ? ('0 - x) : x;
    endfunction

    logic                 sgn_a, sgn_b;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   mul_next;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   prod_fix;

    // Operand magnitudes; op[0]=1 selects the unsigned variants.
    assign sgn_a = ~op[0] & a[WIDTH-1];
    assign sgn_b = ~op[0] & b[WIDTH-1];
    assign mag_a = cond_neg(a, sgn_a);
    assign mag_b = cond_neg(b, sgn_b);

    // Multiply step: acc = {partial high, multiplier bits still to consume}.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide step: acc = {remainder, dividend bits / quotient bits}.
    assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_ge    = ~div_diff[WIDTH];
    assign div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                        acc_q[WIDTH-2:0], div_ge};

    assign prod_fix = cond_neg2(acc_q, qsign_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        qsign_d  = qsign_q;
        rsign_d  = rsign_q;
        dz_d     = dz_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    cnt_d    = '0;
                    is_div_d = op[1];
                    qsign_d  = sgn_a ^ sgn_b;
                    rsign_d  = sgn_a;
                    dz_d     = op[1] & (b == '0);
                    opnd_d   = op[1] ? mag_b : mag_a;
                    acc_d    = {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
                    busy_d   = 1'b1;
                end
            end
            S_RUN: begin
                acc_d = is_div_q ? div_next : mul_next;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FIX: begin
                if (is_div_q) begin
                    // A zero divisor leaves the dividend in the remainder; the quotient is forced.
                    hi_d = cond_neg(acc_q[2*WIDTH-1:WIDTH], rsign_q);
                    lo_d = dz_q ? '1 : cond_neg(acc_q[WIDTH-1:0], qsign_q);
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            qsign_q  <= 1'b0;
            rsign_q  <= 1'b0;
            dz_q     <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            qsign_q  <= qsign_d;
            rsign_q  <= rsign_d;
            dz_q     <= dz_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
